mconverter_pipe: RTL and testbench

Pipelined, handshaked int-to-FP16 converter for the MArray output path. It accepts one tile of signed or unsigned shifted accumulator sums (ROWS×COLS integers) and converts LANES elements per cycle through a 2-stage lane pipeline. It reassembles the FP16 tile, reports sticky per-tile status, and holds the result until the consumer accepts it. The block sits between the shifter stage and the FP16 writeback, and time-multiplexes a small number of converter lanes instead of instantiating one converter per element.

---
 rtl/mconverter_pipe_pkg.sv | 43 ++++
 rtl/mconverter_pipe_lane.sv | 98 +++++++++
 rtl/mconverter_pipe.sv | 141 ++++++++++++++
 tb/tb_mconverter_pipe.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mconverter_pipe_pkg.sv
// Shared types and constants for the MArray int-to-FP16 output converter.
package mconverter_pipe_pkg;

  localparam int unsigned MPERow = 4;
  localparam int unsigned MPECol = 4;
  localparam int unsigned MPEAcc = 4;

  typedef logic [15:0] fp16_t;

  localparam int unsigned FP16_BIAS   = 15;
  localparam fp16_t       FP16_MAXFIN = 16'h7BFF;
  localparam fp16_t       FP16_INF    = 16'h7C00;

  typedef enum logic {
    RND_RNE = 1'b0,
    RND_RTZ = 1'b1
  } rnd_mode_e;

  localparam int unsigned ST_INEXACT  = 0;
  localparam int unsigned ST_OVERFLOW = 1;
  localparam int unsigned ST_ZERO     = 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Leading-zero count of a 32-bit word; returns 32 for an all-zero input.
  function automatic logic [5:0] lzc32(input logic [31:0] v);
    logic [5:0] n;
    logic       found;
    n     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (!found) begin
        if (v[31-i]) found = 1'b1;
        else         n     = n + 6'd1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/mconverter_pipe_lane.sv
// One 2-stage IN_W-bit integer to FP16 converter lane with valid and flag outputs.
module mconv_i2h_lane
  import mconverter_pipe_pkg::*;
#(
  parameter int unsigned IN_W = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [IN_W-1:0] data_i,
  input  logic            signed_i,
  input  rnd_mode_e       rnd_i,
  output logic            valid_o,
  output fp16_t           res_o,
  output logic            inexact_o,
  output logic            ovf_o,
  output logic            zero_o
);

  logic            neg;
  logic [IN_W-1:0] neg_val;
  logic [31:0]     mag;
  logic [5:0]      lz;

  always_comb begin
    neg     = signed_i & data_i[IN_W-1];
    neg_val = ~data_i + IN_W'(1);
    mag     = neg ? 32'(neg_val) : 32'(data_i);
    lz      = lzc32(mag);
  end

  logic        v1_q, sign1_q, zero1_q;
  rnd_mode_e   rnd1_q;
  logic [4:0]  exp1_q;
  logic [31:0] norm1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      sign1_q <= 1'b0;
      zero1_q <= 1'b0;
      rnd1_q  <= RND_RNE;
      exp1_q  <= '0;
      norm1_q <= '0;
    end else begin
      v1_q    <= valid_i;
      sign1_q <= neg;
      zero1_q <= (mag == '0);
      rnd1_q  <= rnd_i;
      exp1_q  <= 5'(6'd31 - lz);
      norm1_q <= mag << lz;
    end
  end

  // Normalised word has its hidden one at bit 31: [30:21] mantissa, [20] guard, rest sticky.
  logic [9:0]  mant;
  logic        guard, sticky, rup, ovf, inexact;
  logic [10:0] sum;
  logic [5:0]  exp_r;
  fp16_t       res;

  always_comb begin
    mant    = norm1_q[30:21];
    guard   = norm1_q[20];
    sticky  = |norm1_q[19:0];
    rup     = (rnd1_q == RND_RNE) & guard & (sticky | mant[0]);
    sum     = {1'b0, mant} + 11'(rup);
    exp_r   = {1'b0, exp1_q} + 6'(sum[10]);
    ovf     = (exp1_q > 5'd15) | ((exp1_q == 5'd15) & (&mant) & (guard | sticky));
    inexact = guard | sticky | ovf;
    res     = '0;
    if (zero1_q) begin
      ovf     = 1'b0;
      inexact = 1'b0;
    end else if (exp_r > 6'(FP16_BIAS)) begin
      res = {sign1_q, (rnd1_q == RND_RTZ) ? FP16_MAXFIN[14:0] : FP16_INF[14:0]};
    end else begin
      res = {sign1_q, 5'(exp_r + 6'(FP16_BIAS)), sum[9:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_o   <= 1'b0;
      res_o     <= '0;
      inexact_o <= 1'b0;
      ovf_o     <= 1'b0;
      zero_o    <= 1'b0;
    end else begin
      valid_o   <= v1_q;
      res_o     <= res;
      inexact_o <= inexact;
      ovf_o     <= ovf;
      zero_o    <= zero1_q;
    end
  end

endmodule

// File: rtl/mconverter_pipe.sv
// Handshaked tile converter: time-multiplexes LANES int-to-FP16 lanes over a ROWS x COLS tile.
module mconverter_pipe
  import mconverter_pipe_pkg::*;
#(
  parameter int unsigned ROWS  = MPERow - 1,
  parameter int unsigned COLS  = MPECol,
  parameter int unsigned IN_W  = 8 + 2 + $clog2(MPEAcc) + 8,
  parameter int unsigned LANES = COLS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ROWS*COLS*IN_W-1:0] in_tile,
  input  logic                      in_signed,
  input  logic                      in_rnd,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ROWS*COLS*16-1:0]   out_tile,
  output logic [2:0]                out_status
);

  localparam int unsigned N  = ROWS * COLS;
  localparam int unsigned B  = N / LANES;
  localparam int unsigned BW = (B > 1) ? $clog2(B) : 1;

  if ((N % LANES) != 0) begin : g_bad_lanes
    $error("mconverter_pipe: LANES must divide ROWS*COLS");
  end
  if ((IN_W < 2) || (IN_W > 32)) begin : g_bad_width
    $error("mconverter_pipe: IN_W must be in 2..32");
  end

  logic [1:0]        state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d, wb_q, wb_d, beat1_q, beat2_q;
  logic [N*IN_W-1:0] ibuf_q;
  logic              sgn_q;
  rnd_mode_e         rnd_q;
  logic [N*16-1:0]   obuf_q, obuf_d;
  logic [2:0]        stat_q, stat_d;

  logic              issue;
  logic [IN_W-1:0]   lane_data [LANES];
  logic [LANES-1:0]  lv, linx, lovf, lzero;
  fp16_t             lres [LANES];
  logic              wb_valid;

  assign issue     = (state_q == S_ISSUE);
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_tile  = obuf_q;
  assign out_status = stat_q;
  assign wb_valid  = &lv;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_data[l] = ibuf_q[(int'(beat_q) * int'(LANES) + l) * int'(IN_W) +: IN_W];

    mconv_i2h_lane #(.IN_W(IN_W)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .valid_i   (issue),
      .data_i    (lane_data[l]),
      .signed_i  (sgn_q),
      .rnd_i     (rnd_q),
      .valid_o   (lv[l]),
      .res_o     (lres[l]),
      .inexact_o (linx[l]),
      .ovf_o     (lovf[l]),
      .zero_o    (lzero[l])
    );
  end

  // Input buffer is deliberately left out of reset; rst only gates the capture.
  always_ff @(posedge clk) begin
    if (!rst && in_ready && in_valid) begin
      ibuf_q <= in_tile;
      sgn_q  <= in_signed;
      rnd_q  <= rnd_mode_e'(in_rnd);
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    wb_d    = wb_q;
    obuf_d  = obuf_q;
    stat_d  = stat_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_ISSUE;
          beat_d  = '0;
          wb_d    = '0;
          stat_d  = '0;
          stat_d[ST_ZERO] = 1'b1;
        end
      end
      S_ISSUE: begin
        if (beat_q == BW'(B - 1)) state_d = S_DRAIN;
        else                      beat_d  = beat_q + BW'(1);
      end
      S_DRAIN: begin
        if (wb_valid && (wb_q == BW'(B - 1))) state_d = S_DONE;
      end
      default: begin
        if (out_ready) state_d = S_IDLE;
      end
    endcase
    // Writebacks overlap the ISSUE/DRAIN cycles, steered by the beat index delayed through both lane stages.
    if (wb_valid) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        obuf_d[(int'(beat2_q) * int'(LANES) + int'(l)) * 16 +: 16] = lres[l];
      end
      stat_d[ST_INEXACT]  = stat_q[ST_INEXACT]  | (|linx);
      stat_d[ST_OVERFLOW] = stat_q[ST_OVERFLOW] | (|lovf);
      stat_d[ST_ZERO]     = stat_q[ST_ZERO]     & (&lzero);
      wb_d = wb_q + BW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      wb_q    <= '0;
      beat1_q <= '0;
      beat2_q <= '0;
      obuf_q  <= '0;
      stat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      wb_q    <= wb_d;
      beat1_q <= beat_q;
      beat2_q <= beat1_q;
      obuf_q  <= obuf_d;
      stat_q  <= stat_d;
    end
  end

endmodule

// File: tb/tb_mconverter_pipe.sv
// Randomized self-checking bench for mconverter_pipe against an arithmetic FP16 reference.
module tb_mconverter_pipe;

  localparam int unsigned ROWS  = 3;
  localparam int unsigned COLS  = 4;
  localparam int unsigned IN_W  = 20;
  localparam int unsigned LANES = 2;
  localparam int unsigned N     = ROWS * COLS;
  localparam int unsigned B     = N / LANES;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [N*IN_W-1:0]    in_tile = '0;
  logic                 in_signed = 1'b0;
  logic                 in_rnd = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [N*16-1:0]      out_tile;
  logic [2:0]           out_status;

  int n_checks = 0;
  int n_errors = 0;

  logic [IN_W-1:0] tv [N];
  logic [15:0]     exp_fp [N];
  logic [2:0]      exp_st;

  mconverter_pipe #(.ROWS(ROWS), .COLS(COLS), .IN_W(IN_W), .LANES(LANES)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_tile    (in_tile),
    .in_signed  (in_signed),
    .in_rnd     (in_rnd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_tile   (out_tile),
    .out_status (out_status)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: returns {zero, overflow, inexact, fp16} from plain integer arithmetic.
  function automatic logic [18:0] ref_conv(input logic [IN_W-1:0] raw, input bit sgn, input bit rtz);
    longint v, mag, q, rem, half;
    int     e, sh;
    bit     neg, ovf, inx;
    logic [15:0] f;
    v = longint'(raw);
    if (sgn && raw[IN_W-1]) v = v - (longint'(1) << IN_W);
    neg = (v < 0);
    mag = neg ? -v : v;
    if (mag == 0) return {3'b100, 16'h0000};
    e = 0;
    while ((mag >> (e + 1)) != 0) e++;
    rem = 0;
    if (e <= 10) begin
      q = mag << (10 - e);
    end else begin
      sh   = e - 10;
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = longint'(1) << (sh - 1);
      if (!rtz && ((rem > half) || ((rem == half) && (q % 2 == 1)))) q++;
      if (q == 2048) begin
        q = 1024;
        e++;
      end
    end
    ovf = (mag > 65504);
    inx = (rem != 0) || ovf;
    f[15] = neg;
    if (e > 15) f[14:0] = rtz ? 15'h7BFF : 15'h7C00;
    else        f[14:0] = 15'(((e + 15) << 10) + (q - 1024));
    return {1'b0, ovf, inx, f};
  endfunction

  task automatic set_tile(input bit sgn, input bit rtz);
    logic [18:0] r;
    exp_st = 3'b100;
    for (int i = 0; i < N; i++) begin
      r = ref_conv(tv[i], sgn, rtz);
      exp_fp[i] = r[15:0];
      exp_st[0] = exp_st[0] | r[16];
      exp_st[1] = exp_st[1] | r[17];
      exp_st[2] = exp_st[2] & r[18];
      in_tile[i*IN_W +: IN_W] = tv[i];
    end
    in_signed = sgn;
    in_rnd    = rtz;
  endtask

  task automatic send(input string tag);
    in_valid = 1'b1;
    check_eq({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic collect(input string tag, input bit handshake);
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk);
      #1 cyc++;
    end
    check_eq({tag, "_lat"}, 32'(cyc), 32'(B + 2));
    for (int i = 0; i < N; i++)
      check_eq($sformatf("%s_e%0d", tag, i), 32'(out_tile[i*16 +: 16]), 32'(exp_fp[i]));
    check_eq({tag, "_st"}, 32'(out_status), 32'(exp_st));
    if (handshake) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check_eq({tag, "_idle"}, {30'd0, in_ready, out_valid}, 32'b10);
    end
  endtask

  function automatic logic [IN_W-1:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return IN_W'($urandom_range(0, 2047));
      2:       return IN_W'($urandom_range(65490, 65540));
      3:       return IN_W'(0 - int'($urandom_range(1, 70000)));
      4:       return IN_W'($urandom_range(2048, 65000));
      default: return IN_W'($urandom);
    endcase
  endfunction

  task automatic clear_tv();
    for (int i = 0; i < N; i++) tv[i] = '0;
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    check_eq("rst_out", {28'd0, out_status, out_valid}, 32'd0);
    check_eq("rst_rdy", 32'(in_ready), 32'd1);
    check_eq("rst_tile", 32'(|out_tile), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Small signed values, RNE
    clear_tv();
    tv[0] = IN_W'(1);
    tv[1] = IN_W'(-2);
    set_tile(1'b1, 1'b0);
    send("t1");
    collect("t1", 1'b1);
    check_eq("t1_c0", 32'(out_tile[15:0]), 32'h3C00);
    check_eq("t1_c1", 32'(out_tile[31:16]), 32'hC000);

    // RNE ties and rounding into infinity
    clear_tv();
    tv[0] = IN_W'(2049);
    tv[1] = IN_W'(2051);
    tv[2] = IN_W'(65520);
    set_tile(1'b1, 1'b0);
    send("t2");
    collect("t2", 1'b0);
    check_eq("t2_c", {out_tile[47:32], out_tile[31:16]}, {16'h7C00, 16'h6802});
    check_eq("t2_c0", 32'(out_tile[15:0]), 32'h6800);
    check_eq("t2_cs", 32'(out_status), 32'b011);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;

    // RTZ truncation and saturation
    clear_tv();
    tv[0] = IN_W'(2051);
    tv[1] = IN_W'(65535);
    tv[2] = IN_W'(-65535);
    set_tile(1'b1, 1'b1);
    send("t3");
    collect("t3", 1'b1);
    check_eq("t3_c", {out_tile[47:32], out_tile[31:16]}, {16'hFBFF, 16'h7BFF});

    // Same bit pattern interpreted unsigned vs signed
    clear_tv();
    tv[0] = IN_W'(8'hFF);
    tv[1] = '1;
    set_tile(1'b0, 1'b0);
    send("t4u");
    collect("t4u", 1'b1);
    check_eq("t4u_c0", 32'(out_tile[15:0]), 32'h5BF8);
    clear_tv();
    tv[0] = '1;
    set_tile(1'b1, 1'b0);
    send("t4s");
    collect("t4s", 1'b1);
    check_eq("t4s_c0", 32'(out_tile[15:0]), 32'hBC00);

    // All-zero tile, then backpressure with a second tile waiting
    clear_tv();
    set_tile(1'b1, 1'b0);
    send("t5");
    collect("t5", 1'b0);
    for (int i = 0; i < N; i++) tv[i] = rnd_val();
    set_tile(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check_eq("bp_hold", {27'd0, out_status, 1'(|out_tile), out_valid, in_ready}, {27'd0, 3'b100, 1'b0, 1'b1, 1'b0});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check_eq("bp_idle", {30'd0, in_ready, out_valid}, 32'b10);
    @(posedge clk);
    #1 in_valid = 1'b0;
    collect("t6", 1'b1);

    // Reset during the second issue beat aborts the tile
    for (int i = 0; i < N; i++) tv[i] = IN_W'($urandom_range(60000, 70000));
    set_tile(1'b0, 1'b0);
    send("t7");
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_eq("rstm_out", {30'd0, in_ready, out_valid}, 32'b10);
    @(posedge clk);
    #1 rst = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 15; c++) begin
        @(posedge clk);
        #1 if (out_valid) seen++;
      end
      check_eq("rstm_novalid", 32'(seen), 32'd0);
    end
    check_eq("rstm_state", {28'd0, out_status, in_ready}, 32'd1);
    clear_tv();
    tv[3] = IN_W'(100);
    set_tile(1'b1, 1'b0);
    send("t8");
    collect("t8", 1'b1);

    // Randomized tiles
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < N; i++) tv[i] = rnd_val();
      set_tile(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      send($sformatf("r%0d", t));
      collect($sformatf("r%0d", t), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
